fifo_wr_ctrl: RTL
=================

# fifo_wr_ctrl

Write-side control for the asynchronous FIFO, in the write clock domain. It owns the write pointer and drives the dual-port RAM write port. It publishes a registered Gray-coded write pointer for the pointer synchronizer into the read domain. It consumes the read pointer already synchronized into the write domain and generates full, almost-full, fill level and a sticky overflow flag.

## Interface
- ADDR_WIDTH, 10, RAM address width; FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range ≥ 2
- AFULL_THRESH, 2**ADDR_WIDTH-4, fill level at or above which almost_full asserts
- wr_clk  in  1  write-domain clock; all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_en  in  1  write request from producer
- rptr_sync  in  ADDR_WIDTH+1  Gray read pointer, already two-flop synchronized into wr_clk
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, to the read-domain synchronizer
- ram_waddr  out  ADDR_WIDTH  RAM write address = low ADDR_WIDTH bits of binary write pointer
- ram_we  out  1  RAM write enable = accepted write this cycle
- full  out  1  registered full flag
- almost_full  out  1  registered, level ≥ AFULL_THRESH
- wr_level  out  ADDR_WIDTH+1  registered fill level as seen from write side, 0..2**ADDR_WIDTH
- overflow  out  1  sticky: a write was attempted while full

## Operation
- accept = wr_en & ~full; ram_we = accept (combinational); ram_waddr = wbin[ADDR_WIDTH-1:0] (combinational from register)
- wbin_next = wbin + accept, modulo 2**(ADDR_WIDTH+1); wgray_next = wbin_next ^ (wbin_next >> 1)
- wbin, wptr_gray register wbin_next, wgray_next each cycle; wptr_gray only ever changes by one bit per cycle
- full_next = (wgray_next == {~rptr_sync[AW:AW-1], rptr_sync[AW-2:0]}), AW = ADDR_WIDTH
- rbin = Gray-to-binary of rptr_sync (combinational XOR prefix); level_next = (wbin_next - rbin) mod 2**(AW+1)
- wr_level ← level_next; almost_full ← (level_next ≥ AFULL_THRESH)
- overflow ← overflow | (wr_en & full); cleared only by reset
- Write while full: dropped; no RAM write, pointer, level unchanged
- Pointer wrap: binary pointer rolls 2**(AW+1)-1 → 0; MSB toggles every depth writes, distinguishing full from empty
- Simultaneous write and rptr_sync change: both used in same next-state computation; no priority needed
- No FSM beyond pointer/flag registers; read pointer never decreases modulo wrap

## Timing
- Reset (rst_n low at a wr_clk edge): wbin=0, wptr_gray=0, full=0, almost_full=0, wr_level=0, overflow=0; ram_we=0 while in reset (accept forced 0)
- Reset mid-operation: all state returns to zero on that edge regardless of wr_en; read side must be reset concurrently
- full asserts on the edge that accepts the filling write; next cycle's wr_en is rejected
- full/level are conservative: a read becomes visible ≥2 wr_clk after the read pointer changes (synchronizer), plus 1 cycle here for deassertion
- ram_we/ram_waddr valid in same cycle as wr_en; RAM captures at that edge
- wptr_gray updated 1 cycle after accept; reaches read domain 2 rd_clk later

## Structure
- Shared package fifo_pkg: ADDR_WIDTH default, pointer width localparam, bin2gray/gray2bin functions (used by write and read control)
- One sub-module natural: gray2bin (parameterized width, combinational); bin2gray inline
- Top async FIFO instantiates fifo_wr_ctrl, sync (×2), read control, RAM

## Test plan
- ADDR_WIDTH=3, rptr_sync=0, wr_en high 9 cycles → 8 ram_we pulses addr 0..7; full=1 after 8th accept; wptr_gray=4'b1100; wr_level=8; 9th write dropped, overflow=1
- Continue from full, set rptr_sync=4'b0010 (bin 3) → full=0 next cycle, wr_level=5, almost_full(THRESH=6)=0
- AFULL_THRESH=6, rptr_sync=0, write 6 → almost_full=1 on 6th accept edge, 0 after 5
- Wrap: alternate writes with rptr_sync tracking wbin−1 for 40 writes → wbin rolls 15→0, wptr_gray changes 1 bit per step, full never set, wr_level=1
- Reset mid-burst at level 5 with overflow=1 → all outputs 0 next edge; ram_we=0 during reset with wr_en=1
- wr_en=1 while full with rptr_sync static → ram_we stays 0, wptr_gray stable, overflow stays 1 until reset

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO write and read control blocks.
// Provides the default address width, the derived pointer width and the
// binary/Gray conversion helpers.
//
// The helpers work on a 32-bit word. Callers zero-extend their pointer into
// the word and truncate the result back to pointer width. Zero extension does
// not change either conversion, so one function covers every pointer width.
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 10;
    localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;
    localparam int FIFO_FUNC_WIDTH = 32;

    typedef logic [FIFO_FUNC_WIDTH-1:0] fifo_word_t;

    function automatic fifo_word_t bin2gray(input fifo_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above its position.
    function automatic fifo_word_t gray2bin(input fifo_word_t gray);
        fifo_word_t bin;
        bin = '0;
        for (int i = 0; i < FIFO_FUNC_WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage

// File: rtl/fifo_wr_ctrl_gray2bin.sv
// Combinational Gray-to-binary converter with a parameterised width.
// Ports:
//   gray : Gray-coded input value
//   bin  : binary equivalent of gray
module gray2bin #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Each output bit is computed directly from the Gray input rather than
    // from the neighbouring output bit. This avoids a chain of dependencies
    // inside the output vector.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side control for the asynchronous FIFO, running in the write clock
// domain. This block:
//   - owns the binary write pointer;
//   - drives the write port of the dual-port RAM;
//   - publishes a registered Gray write pointer for the read domain;
//   - derives full, almost_full, fill level and a sticky overflow flag from
//     the read pointer, which arrives already synchronised into this domain.
// Ports:
//   wr_clk      : write-domain clock (rising edge)
//   rst_n       : synchronous active-low reset
//   wr_en       : write request from the producer
//   rptr_sync   : Gray read pointer, synchronised into wr_clk
//   wptr_gray   : registered Gray write pointer, to the read-domain synchroniser
//   ram_waddr   : RAM write address (low bits of the binary write pointer)
//   ram_we      : RAM write enable (an accepted write this cycle)
//   full        : registered full flag
//   almost_full : registered flag, set when the fill level is >= AFULL_THRESH
//   wr_level    : registered fill level, 0..2**ADDR_WIDTH
//   overflow    : sticky flag, set when a write is attempted while full
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
    parameter int AFULL_THRESH = 2**ADDR_WIDTH - 4
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rptr_sync,
    output logic [ADDR_WIDTH:0]   wptr_gray,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rgray_full;
    logic [PW-1:0] level_next;
    logic          accept;

    gray2bin #(.WIDTH(PW)) u_rptr_g2b (
        .gray (rptr_sync),
        .bin  (rbin)
    );

    // Gating with rst_n guarantees no RAM write while reset is held.
    assign accept    = rst_n & wr_en & ~full;
    assign ram_we    = accept;
    assign ram_waddr = wbin[ADDR_WIDTH-1:0];

    assign wbin_next  = wbin + PW'(accept);
    assign wgray_next = PW'(bin2gray(fifo_word_t'(wbin_next)));

    // In Gray code, the "full" write pointer equals the read pointer with its
    // top two bits inverted. That position is exactly one depth ahead of the
    // read pointer.
    assign rgray_full = {~rptr_sync[PW-1:PW-2], rptr_sync[PW-3:0]};
    assign level_next = wbin_next - rbin;

    always_ff @(posedge wr_clk) begin
        if (!rst_n) begin
            wbin        <= '0;
            wptr_gray   <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_next;
            wptr_gray   <= wgray_next;
            full        <= (wgray_next == rgray_full);
            almost_full <= (level_next >= AFULL_LVL);
            wr_level    <= level_next;
            overflow    <= overflow | (wr_en & full);
        end
    end

endmodule
